// File: rtl/decade_div_cascade.sv
// Synchronous cascade of modulo-RADIX digit counters producing per-stage enable
// ticks and a 50%-duty square wave selected from any stage. No derived clocks.
module decade_div_cascade #(
  parameter int STAGES  = 4,
  parameter int RADIX   = 10,
  parameter int DIGIT_W = 4,
  parameter int SEL_W   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic [SEL_W-1:0]            tap_sel,
  output logic [STAGES-1:0]           tick,
  output logic                        sq_out,
  output logic [STAGES*DIGIT_W-1:0]   count
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(RADIX - 1);
  localparam int                 TAPS      = 1 << SEL_W;

  logic [STAGES-1:0] wrap;
  logic [TAPS-1:0]   tap_wrap;
  logic [STAGES-1:0] tick_reg;
  logic              sq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic               inc;
      logic [DIGIT_W-1:0] digit_reg;
      logic [DIGIT_W-1:0] digit_next;

      // wrap(i) = wrap(i-1) & digit i at max, with wrap(-1) being en itself
      if (gi == 0) begin : g_first
        assign inc = en;
      end else begin : g_rest
        assign inc = wrap[gi-1];
      end

      assign wrap[gi] = inc && (digit_reg == DIGIT_MAX);

      always_comb begin
        digit_next = digit_reg;
        if (clr) begin
          digit_next = '0;
        end else if (wrap[gi]) begin
          digit_next = '0;
        end else if (inc) begin
          digit_next = digit_reg + DIGIT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          digit_reg <= '0;
        end else begin
          digit_reg <= digit_next;
        end
      end

      assign count[gi*DIGIT_W +: DIGIT_W] = digit_reg;
    end

    // Out-of-range tap codes alias the last stage, so the mux is always full.
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi < STAGES) begin : g_real
        assign tap_wrap[gi] = wrap[gi];
      end else begin : g_clamp
        assign tap_wrap[gi] = wrap[STAGES-1];
      end
    end
  endgenerate

  // sq_out only ever toggles on a wrap of the selected stage: no runt pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_reg <= '0;
      sq_reg   <= 1'b0;
    end else if (clr) begin
      tick_reg <= '0;
      sq_reg   <= 1'b0;
    end else begin
      tick_reg <= wrap;
      if (tap_wrap[tap_sel]) begin
        sq_reg <= ~sq_reg;
      end
    end
  end

  assign tick   = tick_reg;
  assign sq_out = sq_reg;

endmodule

// File: tb/tb_decade_div_cascade.sv
// Bench for decade_div_cascade: table vectors, directed corner sequences and
// random stimulus, all checked against an arithmetic enabled-cycle-count model.
module tb_decade_div_cascade;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  tap_sel = 2'd0;
  logic [3:0]  tick;
  logic        sq_out;
  logic [15:0] count;

  logic [1:0]  tap3 = 2'd3;
  logic [2:0]  tick3;
  logic        sq3;
  logic [11:0] count3;

  decade_div_cascade #(.STAGES(4), .RADIX(10), .DIGIT_W(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .tap_sel(tap_sel),
    .tick(tick), .sq_out(sq_out), .count(count)
  );

  decade_div_cascade #(.STAGES(3), .RADIX(10), .DIGIT_W(4), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .tap_sel(tap3),
    .tick(tick3), .sq_out(sq3), .count(count3)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: n = enabled edges since reset/clear, modulo 10^4.
  int         n_m = 0;
  logic [3:0] tick_m = '0;
  logic       sq_m = 1'b0;
  logic       sq3_m = 1'b0;
  int         pw[4] = '{10, 100, 1000, 10000};

  typedef struct {
    logic        e;
    logic        c;
    logic [1:0]  t;
    int          n;
    logic [15:0] cnt;
    logic [3:0]  tk;
    logic        sq;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    n_m = 0;
    tick_m = '0;
    sq_m = 1'b0;
    sq3_m = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic c, input logic [1:0] t);
    int n1;
    if (c) begin
      model_reset();
    end else if (e) begin
      n1 = n_m + 1;
      for (int i = 0; i < 4; i++) tick_m[i] = (n1 % pw[i] == 0);
      if (n1 % pw[t] == 0) sq_m = ~sq_m;
      if (n1 % 1000 == 0) sq3_m = ~sq3_m;
      n_m = n1 % 10000;
    end else begin
      tick_m = '0;
    end
  endtask

  task automatic check_model();
    logic [15:0] ec;
    ec = bcd(n_m);
    chk("count", 32'(count), 32'(ec));
    chk("tick", 32'(tick), 32'(tick_m));
    chk("sq_out", 32'(sq_out), 32'(sq_m));
    chk("count3", 32'(count3), 32'(ec[11:0]));
    chk("tick3", 32'(tick3), 32'(tick_m[2:0]));
    chk("sq3", 32'(sq3), 32'(sq3_m));
  endtask

  // One clock edge: drive at negedge side, model at posedge, compare at negedge.
  task automatic step(input logic e, input logic c, input logic [1:0] t);
    en = e;
    clr = c;
    tap_sel = t;
    @(posedge clk);
    model_edge(e, c, t);
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input logic e, input logic [1:0] t, input int cycles);
    for (int i = 0; i < cycles; i++) step(e, 1'b0, t);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'd0, 9,    16'h0009, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2'd0, 1,    16'h0010, 4'b0001, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 2'd0, 1,    16'h0011, 4'b0000, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 2'd0, 89,   16'h0100, 4'b0011, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 2'd0, 23,   16'h0123, 4'b0000, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 37,   16'h0123, 4'b0000, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 2'd0, 1,    16'h0000, 4'b0000, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 2'd1, 100,  16'h0100, 4'b0011, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 2'd3, 9900, 16'h0000, 4'b1111, 1'b0};

    // Reset state while rst is held low.
    model_reset();
    @(negedge clk);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_sq", 32'(sq_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table vectors.
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < tbl[v].n; k++) step(tbl[v].e, tbl[v].c, tbl[v].t);
      chk("vec_count", 32'(count), 32'(tbl[v].cnt));
      chk("vec_tick", 32'(tick), 32'(tbl[v].tk));
      chk("vec_sq", 32'(sq_out), 32'(tbl[v].sq));
      $display("vec %0d: en=%0b clr=%0b tap=%0d x%0d -> count=%h tick=%b sq=%b",
               v, tbl[v].e, tbl[v].c, tbl[v].t, tbl[v].n, count, tick, sq_out);
    end

    // tap switch from 0 to 1 at count 0045.
    step(1'b1, 1'b1, 2'd0);
    run(1'b1, 2'd0, 45);
    chk("tapsw_0045_sq", 32'(sq_out), 32'h0);
    run(1'b1, 2'd1, 54);
    chk("tapsw_0099_sq", 32'(sq_out), 32'h0);
    run(1'b1, 2'd1, 1);
    chk("tapsw_0100_sq", 32'(sq_out), 32'h1);
    run(1'b1, 2'd1, 100);
    chk("tapsw_0200_sq", 32'(sq_out), 32'h0);
    $display("seq tap switch: count=%h sq=%b", count, sq_out);

    // en gap of 37 cycles at 0004 delays tick[0] by 37 cycles.
    step(1'b1, 1'b1, 2'd0);
    run(1'b1, 2'd0, 4);
    run(1'b0, 2'd0, 37);
    chk("gap_count", 32'(count), 32'h0004);
    chk("gap_tick", 32'(tick), 32'h0);
    run(1'b1, 2'd0, 5);
    chk("gap_tick_early", 32'(tick), 32'h0);
    run(1'b1, 2'd0, 1);
    chk("gap_tick_late", 32'(tick), 32'h1);
    $display("seq en gap: count=%h tick=%b", count, tick);

    // clr at 0579 with en=1: no tick from the simultaneous wrap.
    step(1'b1, 1'b1, 2'd0);
    run(1'b1, 2'd0, 579);
    step(1'b1, 1'b1, 2'd0);
    chk("clr_count", 32'(count), 32'h0);
    chk("clr_tick", 32'(tick), 32'h0);
    chk("clr_sq", 32'(sq_out), 32'h0);
    run(1'b1, 2'd0, 9);
    chk("clr_tick9", 32'(tick), 32'h0);
    run(1'b1, 2'd0, 1);
    chk("clr_tick10", 32'(tick), 32'h1);
    $display("seq clr at 0579: count=%h tick=%b", count, tick);

    // Async reset between edges at 0320 while tick and sq are high.
    step(1'b1, 1'b1, 2'd1);
    run(1'b1, 2'd1, 320);
    chk("prerst_tick", 32'(tick), 32'h1);
    chk("prerst_sq", 32'(sq_out), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_sq", 32'(sq_out), 32'h0);
    chk("arst_count3", 32'(count3), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    $display("seq async reset: count=%h tick=%b sq=%b", count, tick, sq_out);

    // 3-stage instance with tap 3 behaves as tap 2: period 2000.
    run(1'b1, 2'd0, 999);
    chk("s3_999", 32'(sq3), 32'h0);
    run(1'b1, 2'd0, 1);
    chk("s3_1000", 32'(sq3), 32'h1);
    run(1'b1, 2'd0, 1000);
    chk("s3_2000", 32'(sq3), 32'h0);
    $display("seq 3-stage clamp: count3=%h sq3=%b", count3, sq3);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0),
           2'($urandom_range(0, 3)));
    end
    $display("random: 3000 cycles, count=%h", count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decade_div_cascade.md
Name: decade_div_cascade

Overview:
- Parametrised successor to the fixed four-stage ripple clock divider.
- Single-clock synchronous cascade of STAGES modulo-RADIX digit counters.
- Per-stage one-cycle enable ticks, plus a selectable 50%-duty square output; no derived clocks.
- Sits between the board clock and slow consumers (display scan, debounce, blink logic); those consumers use the ticks as clock enables.

Parameters:
- STAGES, 4, number of cascaded digit counters (1..8).
- RADIX, 10, modulus of each digit counter (2..2^DIGIT_W).
- DIGIT_W, 4, bits per digit in the count output.
- SEL_W, 2, width of tap_sel; must satisfy 2^SEL_W >= STAGES.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; low freezes all state.
- clr  input  1  synchronous clear; priority over en.
- tap_sel  input  SEL_W  stage driving sq_out.
- tick  output  STAGES  tick[i] = one-cycle pulse every RADIX^(i+1) enabled cycles.
- sq_out  output  1  square wave, period 2*RADIX^(tap_sel+1) enabled cycles.
- count  output  STAGES*DIGIT_W  live digit values; digit i at bits [i*DIGIT_W +: DIGIT_W].

Behaviour:
- Reset (rst=0, async, no clock needed): all digits 0, tick=0, sq_out=0. Release is synchronous to the first rising clk edge with rst=1.
- Definition: wrap(i) = en & (digit j == RADIX-1 for all j<=i).
- Each rising edge with clr=0, en=1:
  - digit0 increments; it wraps RADIX-1 -> 0.
  - digit i (i>0) increments only when wrap(i-1); it wraps likewise.
- Ticks are registered: tick[i] <= wrap(i). tick[i] is high for exactly the one cycle following the edge on which digit i's chain wrapped.
  - With en held high from reset release, tick[0] first goes high after the RADIX-th edge.
  - tick[i] first goes high after the RADIX^(i+1)-th edge.
- sq_out: toggles on an edge where wrap(k) is true, k = effective tap.
  - Effective tap = tap_sel, clamped to STAGES-1 when tap_sel >= STAGES.
  - tap_sel is sampled every cycle. A change takes effect at the next wrap of the new stage; sq_out never toggles except on a wrap edge, so there are no runt pulses.
- en=0:
  - digits and sq_out hold.
  - tick outputs are 0 on the following cycle.
  - Count resumes exactly where it stopped; no cycles are lost or added.
- clr=1 at an edge: digits, tick and sq_out all go to 0 on that edge, regardless of en. No tick is generated, even if the count was at a wrap.
- Full wrap (all digits RADIX-1, en=1): all digits go to 0. Every tick[0..STAGES-1] is high in the same following cycle.
- rst asserted mid-count: immediate zeroing as at reset. No partial tick is left on the outputs.
- Digit values never exceed RADIX-1. Unused upper bits of each DIGIT_W field read 0.
- Latency: tick and sq_out change 1 clk after the causing edge's sampled inputs. count reflects the new value after the edge.

Test Plan:
All scenarios use STAGES=4, RADIX=10, DIGIT_W=4 unless stated.
1. Release rst, hold en=1, clr=0 ->
   - tick[0] high for one cycle after edges 10, 20, 30…
   - tick[1] first high after edge 100.
   - tick[3] first high after edge 10000.
   - count=16'h0123 after edge 123.
2. tap_sel=0, en=1 -> sq_out toggles every 10 cycles (period 20, 50% duty). Switch to tap_sel=1 at count 16'h0045 -> next toggle at the edge producing 16'h0100; period 200 thereafter.
3. Drop en at count 16'h0004 for 37 cycles -> count holds 16'h0004, tick stays 0, sq_out holds. The next tick[0] appears 37 cycles later than it would without the gap.
4. At count 16'h0579 with en=1, pulse clr for one edge ->
   - count=16'h0000, sq_out=0, tick=0.
   - No tick[0] from the simultaneous wrap.
   - The next tick[0] appears 10 edges after clr deasserts.
5. Drive count to 16'h9999, one more enabled edge -> count=16'h0000, tick=4'b1111 for exactly one cycle.
6. Assert rst between clk edges at count 16'h0321 -> count, tick and sq_out are 0 before the next edge. Separately, build a STAGES=3, SEL_W=2 variant with tap_sel=3 -> behaves as tap_sel=2 (period 2000).
